// File: rtl/seed_hit_scanner_pkg.sv
// Shared encodings, FSM state type and sizing helpers for the BLAST seed-hit front end.
package blast_pkg;

   localparam int NT_BITS = 2;

   typedef enum logic [1:0] {
      NT_A = 2'd0,
      NT_C = 2'd1,
      NT_G = 2'd2,
      NT_T = 2'd3
   } nucleotideT;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CMP,
      S_EMIT,
      S_ADV
   } scanStateT;

   // Number of seed start positions in the query.
   function automatic int numQueryPos(input int queryLenNt, input int seedNt);
      return queryLenNt - seedNt + 1;
   endfunction

   // Number of seed windows a database chunk yields.
   function automatic int numWindows(input int chunkNt, input int seedNt);
      return chunkNt - seedNt + 1;
   endfunction

endpackage

// File: rtl/seed_hit_scanner_if.sv
// Query load, database chunk and hit stream bundle between the scanner, its feeder and the extension stage.
interface seed_hit_scanner_if #(
   parameter int QUERY_LEN_NT = 256,
   parameter int DB_CHUNK_NT  = 256,
   parameter int DB_LOC_W     = 32
);
   import blast_pkg::*;

   localparam int QW = (QUERY_LEN_NT > 1) ? $clog2(QUERY_LEN_NT) : 1;

   logic [NT_BITS*QUERY_LEN_NT-1:0] query_in;
   logic                            query_valid;
   logic [NT_BITS*DB_CHUNK_NT-1:0]  db_in;
   logic                            db_valid;
   logic                            db_ready;
   logic                            hit_valid;
   logic                            hit_ready;
   logic [QW-1:0]                   hit_q_loc;
   logic [DB_LOC_W-1:0]             hit_db_loc;
   logic [DB_LOC_W-1:0]             hit_count;
   logic                            flush;
   logic                            busy;

   modport master (
      output query_in, query_valid, db_in, db_valid, hit_ready, flush,
      input  db_ready, hit_valid, hit_q_loc, hit_db_loc, hit_count, busy
   );

   modport slave (
      input  query_in, query_valid, db_in, db_valid, hit_ready, flush,
      output db_ready, hit_valid, hit_q_loc, hit_db_loc, hit_count, busy
   );

endinterface

// File: rtl/seed_hit_scanner_enc.sv
// Combinational LSB-first priority encoder: index of the lowest set request bit plus an any-set flag.
module lsb_first_encoder #(
   parameter int N  = 8,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   output logic [IW-1:0] idx,
   output logic          anySet
);

   always_comb begin
      // NOTE: defaults come first so every path assigns both outputs; a missing default infers a latch.
      idx    = '0;
      anySet = 1'b0;
      // Scan high to low so the lowest set bit is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx    = IW'(i);
            anySet = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seed_hit_scanner.sv
// Seed-hit scanner: compares every query seed against a sliding database window in parallel and streams (query, db) hit pairs.
module seed_hit_scanner
   import blast_pkg::*;
#(
   parameter int QUERY_LEN_NT = 256,
   parameter int SEED_NT      = 11,
   parameter int DB_CHUNK_NT  = 256,
   parameter int DB_LOC_W     = 32
) (
   input logic               clk,
   input logic               rst,
   seed_hit_scanner_if.slave bus
);

   localparam int NQ     = numQueryPos(QUERY_LEN_NT, SEED_NT);
   localparam int NWIN   = numWindows(DB_CHUNK_NT, SEED_NT);
   localparam int QW     = (QUERY_LEN_NT > 1) ? $clog2(QUERY_LEN_NT) : 1;
   localparam int WIW    = (NWIN > 1) ? $clog2(NWIN) : 1;
   localparam int SEED_W = NT_BITS * SEED_NT;

   scanStateT                       state;
   scanStateT                       stateNext;
   logic [NT_BITS*QUERY_LEN_NT-1:0] queryReg;
   logic [NT_BITS*DB_CHUNK_NT-1:0]  shReg;
   logic [SEED_W-1:0]               window;
   logic [NQ-1:0]                   cmpVec;
   logic [NQ-1:0]                   mask;
   logic [WIW-1:0]                  winIdx;
   logic [DB_LOC_W-1:0]             dbBase;
   logic [DB_LOC_W-1:0]             hitCount;
   logic [QW-1:0]                   hitIdx;
   logic                            anyHit;
   logic                            lastWin;

   // The current database seed always sits in the low bits of the shift window.
   assign window  = shReg[SEED_W-1:0];
   assign lastWin = (winIdx == WIW'(NWIN - 1));

   for (genvar i = 0; i < NQ; i++) begin : gCmp
      assign cmpVec[i] = (queryReg[NT_BITS*i +: SEED_W] == window);
   end

   lsb_first_encoder #(
      .N  (NQ),
      .IW (QW)
   ) uEnc (
      .req    (mask),
      .idx    (hitIdx),
      .anySet (anyHit)
   );

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) state <= S_IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext      = state;
      bus.db_ready   = (state == S_LOAD);
      bus.busy       = (state != S_IDLE);
      bus.hit_valid  = (state == S_EMIT) && anyHit;
      bus.hit_q_loc  = hitIdx;
      bus.hit_db_loc = dbBase + DB_LOC_W'(winIdx);
      bus.hit_count  = hitCount;
      if (bus.flush) begin
         stateNext = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (bus.query_valid) stateNext = S_LOAD;
            S_LOAD:  if (bus.db_valid) stateNext = S_CMP;
            S_CMP:   stateNext = S_EMIT;
            S_EMIT:  if (!anyHit) stateNext = S_ADV;
            S_ADV:   stateNext = lastWin ? S_LOAD : S_CMP;
            default: stateNext = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: query and window storage are plain flop vectors, not RAM, so they take the reset and the
      // compare array never sees undefined data.
      if (!rst) begin
         queryReg <= '0;
         shReg    <= '0;
         mask     <= '0;
         winIdx   <= '0;
         dbBase   <= '0;
         hitCount <= '0;
      end else if (bus.flush) begin
         mask <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.query_valid) begin
                  queryReg <= bus.query_in;
                  dbBase   <= '0;
                  hitCount <= '0;
               end
            end
            S_LOAD: begin
               if (bus.db_valid) begin
                  shReg  <= bus.db_in;
                  winIdx <= '0;
               end
            end
            S_CMP: mask <= cmpVec;
            S_EMIT: begin
               if (anyHit && bus.hit_ready) begin
                  // x & (x-1) drops exactly the lowest set bit, the one just emitted.
                  mask <= mask & (mask - NQ'(1));
                  if (hitCount != '1) hitCount <= hitCount + DB_LOC_W'(1);
               end
            end
            S_ADV: begin
               if (lastWin) begin
                  dbBase <= dbBase + DB_LOC_W'(NWIN);
               end else begin
                  shReg  <= shReg >> NT_BITS;
                  winIdx <= winIdx + WIW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seed_hit_scanner.sv
// Bench for seed_hit_scanner: vector table, handshake/flush/reset corner cases and randomized sessions against a nucleotide-level model.
module tb_seed_hit_scanner;
   import blast_pkg::*;

   localparam int QL      = 16;
   localparam int SEED    = 4;
   localparam int CL      = 8;
   localparam int LW      = 8;
   localparam int NQ      = QL - SEED + 1;
   localparam int NWIN    = CL - SEED + 1;
   localparam int LOC_MOD = 1 << LW;
   localparam int SAT     = LOC_MOD - 1;

   typedef struct {
      int qLoc;
      int dbLoc;
   } hitT;

   typedef struct {
      string           name;
      logic [2*QL-1:0] query;
      logic [2*CL-1:0] chunk;
      int              nChunks;
      int              expHits;
      int              expFirst;
      int              expDone;
      int              expCount;
   } vecT;

   logic            clk = 1'b0;
   logic            rst;
   int              total = 0;
   int              bad   = 0;
   hitT             expQ[$];
   logic [2*QL-1:0] curQuery;
   int              expBase;
   int              expCount;

   seed_hit_scanner_if #(.QUERY_LEN_NT(QL), .DB_CHUNK_NT(CL), .DB_LOC_W(LW)) bus ();

   seed_hit_scanner #(
      .QUERY_LEN_NT (QL),
      .SEED_NT      (SEED),
      .DB_CHUNK_NT  (CL),
      .DB_LOC_W     (LW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   // String of A/C/G/T, character k becomes nucleotide k.
   function automatic logic [2*QL-1:0] packNt(input string s);
      logic [2*QL-1:0] v;
      nucleotideT      nt;
      v = '0;
      for (int k = 0; k < s.len(); k++) begin
         case (s[k])
            "C":     nt = NT_C;
            "G":     nt = NT_G;
            "T":     nt = NT_T;
            default: nt = NT_A;
         endcase
         v[2*k +: 2] = nt;
      end
      return v;
   endfunction

   // Reference: every (query position, window) pair whose SEED nucleotides agree, in db-then-query order.
   function automatic void modelChunk(input logic [2*CL-1:0] chunk);
      for (int w = 0; w < NWIN; w++) begin
         for (int q = 0; q < NQ; q++) begin
            bit same;
            same = 1'b1;
            for (int k = 0; k < SEED; k++)
               if (curQuery[2*(q+k) +: 2] != chunk[2*(w+k) +: 2]) same = 1'b0;
            if (same) begin
               expQ.push_back('{(q), ((expBase + w) % LOC_MOD)});
               expCount = (expCount < SAT) ? expCount + 1 : SAT;
            end
         end
      end
      expBase = (expBase + NWIN) % LOC_MOD;
   endfunction

   task automatic doFlush();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
   endtask

   task automatic loadQuery(input logic [2*QL-1:0] q);
      bus.query_in    = q;
      bus.query_valid = 1'b1;
      tick();
      bus.query_valid = 1'b0;
      curQuery = q;
      expBase  = 0;
      expCount = 0;
      expQ.delete();
   endtask

   task automatic sendChunk(input logic [2*CL-1:0] chunk);
      int waitCyc;
      waitCyc = 0;
      while (bus.db_ready !== 1'b1 && waitCyc < 8) begin
         tick();
         waitCyc++;
      end
      check("dbReadyWait", bus.db_ready, 1);
      bus.db_in    = chunk;
      bus.db_valid = 1'b1;
      tick();
      bus.db_valid = 1'b0;
   endtask

   // Latencies are counted in clock edges after the accepting edge.
   task automatic runChunk(input logic [2*CL-1:0] chunk, input bit randReady,
                           output int nHits, output int firstLat, output int doneLat);
      hitT e;
      modelChunk(chunk);
      sendChunk(chunk);
      nHits    = 0;
      firstLat = -1;
      doneLat  = -1;
      for (int k = 0; k < 400; k++) begin
         if (bus.db_ready === 1'b1) begin
            doneLat = k;
            break;
         end
         if (bus.hit_valid === 1'b1 && firstLat < 0) firstLat = k;
         bus.hit_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.hit_valid === 1'b1 && bus.hit_ready) begin
            check("hitAvail", (expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
               e = expQ.pop_front();
               check("hitQLoc", bus.hit_q_loc, e.qLoc);
               check("hitDbLoc", bus.hit_db_loc, e.dbLoc);
            end
            nHits++;
         end
         tick();
      end
      check("chunkDone", (doneLat >= 0), 1);
      check("chunkLeftover", expQ.size(), 0);
      check("hitCount", bus.hit_count, expCount);
   endtask

   initial begin
      vecT             vecs[3];
      int              nHits, firstLat, doneLat;
      int              lat, stable, xfers;
      bit              found;
      logic [2*CL-1:0] chunk;
      logic [2*QL-1:0] q;
      int              dbSeq[$];
      int              nCh, alpha;

      vecs[0] = '{"allA",  32'h0, 16'h0,    2, 65,  1, 80, 130};
      vecs[1] = '{"allAT", 32'h0, 16'hFFFF, 1,  0, -1, 15,   0};
      vecs[2] = '{"sat",   32'h0, 16'h0,    4, 65,  1, 80, SAT};

      rst             = 1'b0;
      bus.query_in    = '0;
      bus.query_valid = 1'b0;
      bus.db_in       = '0;
      bus.db_valid    = 1'b0;
      bus.hit_ready   = 1'b0;
      bus.flush       = 1'b0;
      repeat (2) tick();
      check("rst.hitValid", bus.hit_valid, 0);
      check("rst.dbReady", bus.db_ready, 0);
      check("rst.busy", bus.busy, 0);
      check("rst.qLoc", bus.hit_q_loc, 0);
      check("rst.dbLoc", bus.hit_db_loc, 0);
      check("rst.count", bus.hit_count, 0);
      rst = 1'b1;
      tick();

      // Table: fixed query/chunk pairs with hit_ready held high.
      for (int v = 0; v < 3; v++) begin
         doFlush();
         loadQuery(vecs[v].query);
         for (int c = 0; c < vecs[v].nChunks; c++) begin
            runChunk(vecs[v].chunk, 1'b0, nHits, firstLat, doneLat);
            check({vecs[v].name, ".hits"}, nHits, vecs[v].expHits);
            check({vecs[v].name, ".first"}, firstLat, vecs[v].expFirst);
            check({vecs[v].name, ".done"}, doneLat, vecs[v].expDone);
         end
         check({vecs[v].name, ".count"}, bus.hit_count, vecs[v].expCount);
      end

      // Single match with back-pressure: output must hold steady until accepted.
      doFlush();
      loadQuery(packNt("CCCCCCACGTCCCCCC"));
      bus.hit_ready = 1'b0;
      chunk = 16'(packNt("GGACGTAA"));
      sendChunk(chunk);
      lat = 0;
      while (bus.hit_valid !== 1'b1 && lat < 30) begin
         tick();
         lat++;
      end
      check("single.latency", lat, 7);
      check("single.qLoc", bus.hit_q_loc, 6);
      check("single.dbLoc", bus.hit_db_loc, 2);
      stable = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.hit_valid === 1'b1 && bus.hit_q_loc == 6 && bus.hit_db_loc == 2) stable++;
      end
      check("single.stable", stable, 10);
      bus.hit_ready = 1'b1;
      xfers = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.db_ready === 1'b1) break;
         if (bus.hit_valid === 1'b1) xfers++;
         tick();
      end
      check("single.xfers", xfers, 1);
      check("single.count", bus.hit_count, 1);
      check("single.done", bus.db_ready, 1);

      // flush beats a simultaneous query_valid in S_EMIT.
      doFlush();
      loadQuery('0);
      bus.hit_ready = 1'b0;
      sendChunk('0);
      tick();
      check("flushEmit.pre", bus.hit_valid, 1);
      bus.flush       = 1'b1;
      bus.query_valid = 1'b1;
      bus.query_in    = '1;
      tick();
      bus.flush       = 1'b0;
      bus.query_valid = 1'b0;
      check("flushEmit.busy", bus.busy, 0);
      check("flushEmit.hitValid", bus.hit_valid, 0);
      tick();
      check("flushEmit.noLoad", bus.db_ready, 0);

      // flush beats a simultaneous db_valid in S_LOAD.
      loadQuery('0);
      check("flushLoad.ready", bus.db_ready, 1);
      bus.db_in    = '0;
      bus.db_valid = 1'b1;
      bus.flush    = 1'b1;
      tick();
      bus.flush = 1'b0;
      check("flushLoad.busy", bus.busy, 0);
      tick();
      check("flushLoad.ignored", bus.busy, 0);
      bus.db_valid = 1'b0;

      // Asynchronous reset in the middle of S_EMIT.
      doFlush();
      loadQuery('0);
      bus.hit_ready = 1'b1;
      sendChunk('0);
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (bus.hit_valid === 1'b1 && bus.hit_db_loc == 1 && bus.hit_q_loc == 2) found = 1'b1;
         else tick();
      end
      check("rstMid.found", found, 1);
      check("rstMid.preCount", bus.hit_count, 15);
      bus.hit_ready = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("rstMid.hitValid", bus.hit_valid, 0);
      check("rstMid.dbReady", bus.db_ready, 0);
      check("rstMid.busy", bus.busy, 0);
      check("rstMid.qLoc", bus.hit_q_loc, 0);
      check("rstMid.dbLoc", bus.hit_db_loc, 0);
      check("rstMid.count", bus.hit_count, 0);
      repeat (2) tick();
      rst          = 1'b1;
      bus.db_in    = '0;
      bus.db_valid = 1'b1;
      repeat (3) tick();
      check("postRst.busy", bus.busy, 0);
      check("postRst.dbReady", bus.db_ready, 0);
      check("postRst.hitValid", bus.hit_valid, 0);
      bus.db_valid = 1'b0;

      // Randomized sessions of overlapping chunks; the last one is long enough to wrap db_base and saturate hit_count.
      for (int s = 0; s < 7; s++) begin
         nCh   = (s == 6) ? 60 : int'($urandom_range(3, 8));
         alpha = (s % 2 == 0) ? 2 : 4;
         for (int k = 0; k < QL; k++) q[2*k +: 2] = 2'($urandom_range(0, alpha - 1));
         dbSeq.delete();
         for (int k = 0; k < NWIN * nCh + SEED - 1; k++) dbSeq.push_back(int'($urandom_range(0, alpha - 1)));
         doFlush();
         loadQuery(q);
         for (int c = 0; c < nCh; c++) begin
            for (int j = 0; j < CL; j++) chunk[2*j +: 2] = 2'(dbSeq[NWIN*c + j]);
            runChunk(chunk, 1'b1, nHits, firstLat, doneLat);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seed_hit_scanner.md
# seed_hit_scanner

Parametrised seed-hit detector for the BLAST front end. It holds one query sequence and streams database chunks through a nucleotide-granular shift window. Every query seed position is compared against the current database seed in parallel, and every match is emitted in order as a (query offset, database offset) pair on a valid/ready stream. The extension stage consumes that stream, and the block generalises the fixed 256-nt/11-nt hit unit.

## Interface
- QUERY_LEN_NT, 256: query length in nucleotides (2 bits/nt).
- SEED_NT, 11: seed (word) length in nt. NQ = QUERY_LEN_NT-SEED_NT+1 query positions.
- DB_CHUNK_NT, 256: database chunk length in nt. NWIN = DB_CHUNK_NT-SEED_NT+1 windows per chunk.
- DB_LOC_W, 32: width of database position counter and hit counter.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (low = reset).
- query_in  in  2*QUERY_LEN_NT  query, nt k at bits [2k+1:2k].
- query_valid  in  1  load query; honoured only in S_IDLE.
- db_in  in  2*DB_CHUNK_NT  database chunk, same packing.
- db_valid / db_ready  in / out  1  chunk handshake; transfer when both high.
- hit_valid / hit_ready  out / in  1  hit handshake.
- hit_q_loc  out  clog2(QUERY_LEN_NT)  query nt offset of hit.
- hit_db_loc  out  DB_LOC_W  absolute database nt offset of hit.
- hit_count  out  DB_LOC_W  hits accepted since query load, saturating.
- flush  in  1  synchronous abort to S_IDLE.
- busy  out  1  high whenever state != S_IDLE.

## Operation
- States: S_IDLE, S_LOAD, S_CMP, S_EMIT, S_ADV.
- S_IDLE: query_valid captures query_in, clears db_base and hit_count, and moves to S_LOAD.
- S_LOAD: db_ready=1. On transfer, load the shift register, set win_idx=0, and move to S_CMP.
- S_CMP: mask[i] = (query[2i +: 2*SEED_NT] == window), i in 0..NQ-1, where window = shreg[2*SEED_NT-1:0]. Register mask and move to S_EMIT.
- S_EMIT: hit_valid = |mask. hit_q_loc = index of lowest set bit. hit_db_loc = db_base+win_idx.
  - On hit_ready, clear that bit and increment hit_count (saturating at all-ones).
  - When mask==0, move to S_ADV. A window with no hits spends one cycle here.
- S_ADV:
  - If win_idx==NWIN-1: db_base += NWIN, go to S_LOAD.
  - Else: shift shreg right by 2 bits (zero fill), win_idx++, go to S_CMP.
- Chunk overlap: the feeder delivers consecutive chunks overlapping by SEED_NT-1 nt, so db_base advances by NWIN and no seed is lost at chunk boundaries.
- Hits are ordered by ascending db offset, then ascending query offset.
- flush, in any state: go to S_IDLE, clear mask, drop hit_valid next cycle; the query register is retained. flush wins over a simultaneous query_valid or db_valid, and the chunk is not accepted.
- query_valid outside S_IDLE is ignored. db_valid outside S_LOAD is ignored.
- db_base wraps modulo 2^DB_LOC_W.

## Timing
- Reset values: hit_valid=0, db_ready=0, busy=0, hit_q_loc=0, hit_db_loc=0, hit_count=0, state S_IDLE. The query register and shreg are cleared.
- All outputs are registered or decoded from registered state. No input-to-output combinational path; db_ready and hit_valid do not depend on db_valid or hit_ready.
- Chunk accepted at edge t: S_CMP at t, first hit_valid at t+1 (one cycle after S_CMP).
- Cost per window: 3 cycles (CMP, EMIT, ADV), plus 1 cycle per hit with hit_ready held high.
- A hit-free chunk returns db_ready 3*NWIN cycles after acceptance.
- With hit_valid high and hit_ready low, hit_q_loc and hit_db_loc hold stable indefinitely.

## Structure
- Package blast_pkg holds:
  - NT_BITS=2
  - nucleotide encoding A=0, C=1, G=2, T=3
  - the state enum
  - NQ/NWIN helper functions
- Sub-module lsb_first_encoder (parameter N): combinational priority encoder giving the index of the lowest set bit and an any-set flag, instantiated with N=NQ.
- The compare array is a generate loop in the top module.

## Test plan
Parameters for all scenarios: QUERY_LEN_NT=16, SEED_NT=4, DB_CHUNK_NT=8, so NQ=13 and NWIN=5.
- All-A query, all-A chunk, hit_ready=1 -> 65 hits; q_loc 0..12 for each db_loc 0..4 in order; hit_count=65; db_ready returns.
- Repeat the previous stimulus with a second overlapping all-A chunk -> db_loc 5..9; hit_count=130.
- All-A query, all-T chunk -> hit_valid never rises; db_ready reasserts exactly 15 cycles after acceptance.
- Single match (query nt 6..9 = ACGT, chunk nt 2..5 = ACGT, rest distinct) with hit_ready held low 10 cycles -> hit_valid stays high with q_loc=6, db_loc=2 stable; exactly one transfer once hit_ready rises.
- flush and query_valid together in S_EMIT -> S_IDLE next cycle; busy=0, hit_valid=0; the new query is not loaded.
- rst low mid-S_EMIT -> outputs reset immediately (asynchronous); after release, db_valid is ignored until a query is loaded.
